// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   Stage-register fields (datapath -> controller): ifid_rs1/rs2, idex_rd,
//   idex_memread, exmem_branch/zero/memread/memwrite, mem_ready.
//   Control outputs (controller -> datapath): pc_write, ifid_write, pc_src,
//   ifid/idex/exmem_flush, pipe_hold, mem_req, err_trap, stall_cnt, flush_cnt.
// Modports: master = datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic [4:0]  idex_rd;
  logic        idex_memread;
  logic        exmem_branch;
  logic        exmem_zero;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        pc_src;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pipe_hold;
  logic        mem_req;
  logic        err_trap;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, idex_rd, idex_memread,
           exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, mem_ready,
    input  pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush,
           pipe_hold, mem_req, err_trap, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rd, idex_memread,
           exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, mem_ready,
    output pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush,
           pipe_hold, mem_req, err_trap, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Detects load-use hazards, MEM-stage taken branches and multi-cycle data
// memory accesses; drives PC/IF-ID enables, per-register flushes and a hold.
// Ports:
//   clk    - clock, all state updates on posedge
//   rst_n  - asynchronous active-low reset
//   hz     - pipeline_hazard_ctrl_if.slave (stage fields in, controls out)
// Parameters:
//   INIT_CYCLES  full-flush cycles after reset release (1..15)
//   MEM_TIMEOUT  MEM_WAIT cycles tolerated before the error trap (1..255)
// Build option: define PERF_CNT_EN to build the stall/flush event counters;
// otherwise stall_cnt and flush_cnt are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] MEM_TO    = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_MEM_WAIT,
    S_ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic pc_write, ifid_write, pc_src;
  logic ifid_flush, idex_flush, exmem_flush;
  logic pipe_hold, mem_req;

  logic access, taken, load_use;

  assign access   = hz.exmem_memread | hz.exmem_memwrite;
  assign taken    = hz.exmem_branch & hz.exmem_zero;
  assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                    ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    pc_src      = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    mem_req     = 1'b0;

    unique case (state_q)
      S_INIT: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (cnt_q == INIT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RUN: begin
        mem_req = access;
        // A completed access (mem_ready=1) falls through to the branch /
        // load-use / normal decode below, so it costs no stall.
        if (access && !hz.mem_ready) begin
          pipe_hold = 1'b1;
          state_d   = S_MEM_WAIT;
          cnt_d     = 8'd1;
        end else if (taken) begin
          pc_src      = 1'b1;
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        mem_req   = 1'b1;
        // Only the back-end hold releases on completion; PC and IF/ID stay
        // frozen until hazards are re-evaluated in RUN next cycle.
        pipe_hold = ~hz.mem_ready;
        if (hz.mem_ready) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == MEM_TO) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ERROR: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.pc_src      = pc_src;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.pipe_hold   = pipe_hold;
  assign hz.mem_req     = mem_req;
  assign hz.err_trap    = err_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write) stall_cnt_d = stall_cnt_q + 32'd1;
    if (pc_src)    flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int unsigned INIT_CYCLES = 3;
  localparam int unsigned MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed-cycle bookkeeping derived from the rules.
  int unsigned init_seen;   // cycles spent flushing since reset release
  int unsigned wait_seen;   // wait cycles of the outstanding access
  bit          waiting;     // access outstanding after a not-ready RUN cycle
  bit          dead;        // timeout has occurred
  logic [31:0] stall_m, flush_m;

  logic e_pcw, e_ifw, e_src, e_iff, e_idf, e_exf, e_hold, e_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int rs1, input int rs2, input int rd, input bit idmr,
                        input bit br, input bit z, input bit mr, input bit mw, input bit rdy);
    hz.ifid_rs1       = 5'(rs1);
    hz.ifid_rs2       = 5'(rs2);
    hz.idex_rd        = 5'(rd);
    hz.idex_memread   = idmr;
    hz.exmem_branch   = br;
    hz.exmem_zero     = z;
    hz.exmem_memread  = mr;
    hz.exmem_memwrite = mw;
    hz.mem_ready      = rdy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic compute_exp();
    bit acc, lu;
    acc = hz.exmem_memread || hz.exmem_memwrite;
    lu  = hz.idex_memread && hz.idex_rd != 0 &&
          (hz.idex_rd == hz.ifid_rs1 || hz.idex_rd == hz.ifid_rs2);
    {e_pcw, e_ifw, e_src, e_iff, e_idf, e_exf, e_hold, e_req} = '0;
    if (dead || init_seen < INIT_CYCLES) begin
      {e_iff, e_idf, e_exf} = 3'b111;
    end else if (waiting) begin
      e_req  = 1'b1;
      e_hold = !hz.mem_ready;
    end else begin
      e_req = acc;
      if (acc && !hz.mem_ready) e_hold = 1'b1;
      else if (hz.exmem_branch && hz.exmem_zero) begin
        {e_src, e_pcw, e_ifw, e_iff, e_idf, e_exf} = 6'b111111;
      end else if (lu) e_idf = 1'b1;
      else {e_pcw, e_ifw} = 2'b11;
    end
  endtask

  task automatic check_now();
    compute_exp();
    chk("pc_write",    32'(hz.pc_write),    32'(e_pcw));
    chk("ifid_write",  32'(hz.ifid_write),  32'(e_ifw));
    chk("pc_src",      32'(hz.pc_src),      32'(e_src));
    chk("ifid_flush",  32'(hz.ifid_flush),  32'(e_iff));
    chk("idex_flush",  32'(hz.idex_flush),  32'(e_idf));
    chk("exmem_flush", 32'(hz.exmem_flush), 32'(e_exf));
    chk("pipe_hold",   32'(hz.pipe_hold),   32'(e_hold));
    chk("mem_req",     32'(hz.mem_req),     32'(e_req));
    chk("err_trap",    32'(hz.err_trap),    32'(dead));
`ifdef PERF_CNT_EN
    chk("stall_cnt", hz.stall_cnt, stall_m);
    chk("flush_cnt", hz.flush_cnt, flush_m);
`else
    chk("stall_cnt", hz.stall_cnt, 32'h0);
    chk("flush_cnt", hz.flush_cnt, 32'h0);
`endif
  endtask

  task automatic model_update();
    bit acc;
    acc = hz.exmem_memread || hz.exmem_memwrite;
    if (!e_pcw) stall_m++;
    if (e_src)  flush_m++;
    if (dead) begin
    end else if (init_seen < INIT_CYCLES) begin
      init_seen++;
    end else if (waiting) begin
      if (hz.mem_ready) waiting = 1'b0;
      else if (wait_seen == MEM_TIMEOUT) dead = 1'b1;
      else wait_seen++;
    end else if (acc && !hz.mem_ready) begin
      waiting   = 1'b1;
      wait_seen = 1;
    end
  endtask

  // One clock cycle: inputs already applied after a negedge.
  task automatic cyc();
    #1;
    check_now();
    @(posedge clk);
    #1;
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    init_seen = 0; wait_seen = 0; waiting = 1'b0; dead = 1'b0;
    stall_m = '0; flush_m = '0;
    #2;
    check_now();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);

    // Reset and the INIT flush window
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    cyc();                                              // first RUN cycle
    chk("run_pc_write", 32'(hz.pc_write), 32'd1);

    // Two taken branches (second with a load-use pending), then a load-use
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0); cyc();
    idle(); cyc();
    set_in(1, 5, 5, 1, 1, 1, 0, 0, 0); cyc();
    set_in(1, 5, 5, 1, 0, 0, 0, 0, 0); cyc();
    idle(); cyc();
`ifdef PERF_CNT_EN
    chk("perf_flush_total", hz.flush_cnt, 32'd2);
    chk("perf_stall_total", hz.stall_cnt, 32'd4);
`endif

    // rd=0 never stalls; untaken branch is a normal cycle
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0); cyc();
    set_in(7, 3, 3, 1, 0, 0, 0, 0, 1); cyc();
    set_in(2, 2, 0, 0, 1, 0, 0, 0, 0); cyc();

    // Load held for 4 not-ready cycles, then completes
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); cyc();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1); cyc();
    idle(); cyc();
    // Store that completes immediately
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 9) < 7));
      cyc();
    end

    // Timeout: memory never ready
    idle(); cyc();
    for (int i = 0; i < MEM_TIMEOUT + 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); cyc();
    end
    chk("timeout_trap", 32'(hz.err_trap), 32'd1);
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 1); cyc();            // late ready is ignored
    idle(); cyc();
    chk("trap_sticky", 32'(hz.err_trap), 32'd1);

    // Reset clears the trap; more random traffic
    do_reset();
    chk("trap_cleared", 32'(hz.err_trap), 32'd0);
    for (int i = 0; i < 100; i++) begin
      set_in($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
